// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared constants and fetch-state encoding for the
//                instruction fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0), shown in Instr out of reset
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  // Default program counter after reset
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_t;

  // Word-align an address by clearing the two byte-offset bits
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/pc_register.sv
`default_nettype none
// ============================================================================
//  Module      : pc_register
//  Description : 32-bit address register with synchronous reset to a
//                parameterised value and a load enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_register
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  // Hold the address; reset wins over load
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule : pc_register
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Three-state instruction fetch sequencer (FETCH/WAIT/VALID)
//                with redirect, stall, memory timeout/retry and a sticky
//                error flag for misaligned targets and timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        instr_valid,
  output logic        fetch_err
);

  // Counter wide enough to hold TIMEOUT itself
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic [CNT_W-1:0]  wait_cnt;
  logic [31:0]       fetch_pc;
  logic [31:0]       fetch_pc_d;
  logic              fetch_load;
  logic              capture;
  logic              timeout_hit;
  logic              misalign_hit;

  // Address of the next (or outstanding) memory request
  pc_register #(.RESET_PC(RESET_PC)) u_fetch_pc (
    .clk   (clk),
    .reset (reset),
    .load  (fetch_load),
    .d     (fetch_pc_d),
    .q     (fetch_pc)
  );

  // Address of the instruction currently held in Instr
  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .clk   (clk),
    .reset (reset),
    .load  (capture),
    .d     (fetch_pc),
    .q     (PC)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and per-state control strobes
  always_comb begin
    state_d      = state_q;
    fetch_load   = 1'b0;
    fetch_pc_d   = PCPlus4;
    capture      = 1'b0;
    timeout_hit  = 1'b0;
    misalign_hit = 1'b0;
    case (state_q)
      ST_FETCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          capture = 1'b1;
          state_d = ST_VALID;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          // Last allowed WAIT cycle expired: retry the same address
          timeout_hit = 1'b1;
          state_d     = ST_FETCH;
        end
      end
      ST_VALID: begin
        // A stalled VALID cycle holds everything and ignores PCSrc
        if (!stall) begin
          fetch_load = 1'b1;
          if (PCSrc) begin
            fetch_pc_d   = word_align(PCTarget);
            misalign_hit = |PCTarget[1:0];
          end else begin
            fetch_pc_d   = PCPlus4;
          end
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // WAIT-cycle counter: cleared while issuing, counts while waiting
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state_q == ST_FETCH) begin
      wait_cnt <= '0;
    end else if (state_q == ST_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Instruction register, loaded when read data is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      Instr <= NOP_INSTR;
    end else if (capture) begin
      Instr <= imem_rdata;
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_err <= 1'b0;
    end else if (timeout_hit || misalign_hit) begin
      fetch_err <= 1'b1;
    end
  end

  // The request is suppressed while reset is held even though the FSM sits in FETCH
  assign imem_req    = (state_q == ST_FETCH) && !reset;
  assign imem_addr   = fetch_pc;
  assign instr_valid = (state_q == ST_VALID);
  assign PCPlus4     = PC + 32'd4;

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Directed, table-driven self-checking bench for
//                instr_fetch_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        instr_valid;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .PCSrc       (PCSrc),
    .PCTarget    (PCTarget),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .Instr       (Instr),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rvalid;
    logic [31:0] rdata;
    logic        stl;
    logic        src;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pcp4;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic rvalid, input logic [31:0] rdata,
                              input logic stl, input logic src, input logic [31:0] tgt,
                              input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_instr, input logic [31:0] e_pc,
                              input logic [31:0] e_pcp4, input logic e_err);
    vec_t v;
    v.rst = rst; v.rvalid = rvalid; v.rdata = rdata; v.stl = stl; v.src = src; v.tgt = tgt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr;
    v.e_pc = e_pc; v.e_pcp4 = e_pcp4; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic rvalid, input logic [31:0] rdata,
                       input logic stl, input logic src, input logic [31:0] tgt);
    @(negedge clk);
    reset = rst; imem_rvalid = rvalid; imem_rdata = rdata;
    stall = stl; PCSrc = src; PCTarget = tgt;
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v.rst, v.rvalid, v.rdata, v.stl, v.src, v.tgt);
    chk("imem_req",    idx, {31'd0, imem_req},    {31'd0, v.e_req});
    chk("imem_addr",   idx, imem_addr,            v.e_addr);
    chk("instr_valid", idx, {31'd0, instr_valid}, {31'd0, v.e_valid});
    chk("Instr",       idx, Instr,                v.e_instr);
    chk("PC",          idx, PC,                   v.e_pc);
    chk("PCPlus4",     idx, PCPlus4,              v.e_pcp4);
    chk("fetch_err",   idx, {31'd0, fetch_err},   {31'd0, v.e_err});
  endtask

  task automatic run_table(input int base);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], base + i);
    vecs.delete();
  endtask

  initial begin
    reset = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    stall = 1'b0; PCSrc = 1'b0; PCTarget = '0;

    // ---- Reset, first fetch, stall, sequential fetch, aligned/misaligned redirect
    //        rst rv rdata         stl src tgt           req addr          vld instr         pc            pcp4          err
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, NOP,          32'h0,        32'h4,        0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, NOP,          32'h0,        32'h4,        0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        0, NOP,          32'h0,        32'h4,        0));
    vecs.push_back(mk(0, 1, 32'h00500093, 0, 0, 32'h0,        0, 32'h0,        0, NOP,          32'h0,        32'h4,        0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h200,      0, 32'h0,        1, 32'h00500093, 32'h0,        32'h4,        0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h00500093, 32'h0,        32'h4,        0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h300,      0, 32'h0,        1, 32'h00500093, 32'h0,        32'h4,        0));
    vecs.push_back(mk(0, 1, 32'hDEADBEEF, 1, 0, 32'h0,        0, 32'h0,        1, 32'h00500093, 32'h0,        32'h4,        0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1, 32'h00500093, 32'h0,        32'h4,        0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h4,        0, 32'h00500093, 32'h0,        32'h4,        0));
    vecs.push_back(mk(0, 1, 32'h00A00113, 0, 0, 32'h0,        0, 32'h4,        0, 32'h00500093, 32'h0,        32'h4,        0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h100,      0, 32'h4,        1, 32'h00A00113, 32'h4,        32'h8,        0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h100,      0, 32'h00A00113, 32'h4,        32'h8,        0));
    vecs.push_back(mk(0, 1, 32'h11111111, 0, 0, 32'h0,        0, 32'h100,      0, 32'h00A00113, 32'h4,        32'h8,        0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h102,      0, 32'h100,      1, 32'h11111111, 32'h100,      32'h104,      0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h100,      0, 32'h11111111, 32'h100,      32'h104,      1));
    vecs.push_back(mk(0, 1, 32'h22222222, 0, 0, 32'h0,        0, 32'h100,      0, 32'h11111111, 32'h100,      32'h104,      1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h100,      1, 32'h22222222, 32'h100,      32'h104,      1));
    run_table(0);

    // ---- Error flag stays set across ten further stalled cycles
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 32'h0, 1, 1, 32'h0);
      chk("err_sticky",   100 + i, {31'd0, fetch_err},   32'd1);
      chk("stall_hold",   100 + i, {31'd0, instr_valid}, 32'd1);
    end

    // ---- Timeout: 16 WAIT cycles without rvalid, then retry at the same address
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    chk("to_req",  200, {31'd0, imem_req},  32'd1);
    chk("to_addr", 200, imem_addr,          32'h0);
    chk("to_err0", 200, {31'd0, fetch_err}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 32'h0, 0, 0, 32'h0);
      chk("to_wait_req", 201 + i, {31'd0, imem_req},    32'd0);
      chk("to_wait_err", 201 + i, {31'd0, fetch_err},   32'd0);
      chk("to_wait_vld", 201 + i, {31'd0, instr_valid}, 32'd0);
    end
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    chk("to_retry_req",  220, {31'd0, imem_req},  32'd1);
    chk("to_retry_addr", 220, imem_addr,          32'h0);
    chk("to_retry_err",  220, {31'd0, fetch_err}, 32'd1);
    drive(0, 1, 32'h33333333, 0, 0, 32'h0);
    chk("to_rsp_req", 221, {31'd0, imem_req}, 32'd0);

    // ---- PC wrap, then reset pulse mid-WAIT followed by a stray rvalid
    //        rst rv rdata         stl src tgt           req addr          vld instr         pc            pcp4          err
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hFFFFFFFC, 0, 32'h0,        1, 32'h33333333, 32'h0,        32'h4,        1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h33333333, 32'h0,        32'h4,        1));
    vecs.push_back(mk(0, 1, 32'h44444444, 0, 0, 32'h0,        0, 32'hFFFFFFFC, 0, 32'h33333333, 32'h0,        32'h4,        1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'hFFFFFFFC, 1, 32'h44444444, 32'hFFFFFFFC, 32'h0,        1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        0, 32'h44444444, 32'hFFFFFFFC, 32'h0,        1));
    vecs.push_back(mk(0, 1, 32'h55555555, 0, 0, 32'h0,        0, 32'h0,        0, 32'h44444444, 32'hFFFFFFFC, 32'h0,        1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h40,       0, 32'h0,        1, 32'h55555555, 32'h0,        32'h4,        1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h40,       0, 32'h55555555, 32'h0,        32'h4,        1));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h40,       0, 32'h55555555, 32'h0,        32'h4,        1));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, NOP,          32'h0,        32'h4,        0));
    vecs.push_back(mk(0, 1, 32'h66666666, 0, 0, 32'h0,        1, 32'h0,        0, NOP,          32'h0,        32'h4,        0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, NOP,          32'h0,        32'h4,        0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, NOP,          32'h0,        32'h4,        0));
    run_table(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_instr_fetch_unit
`default_nettype wire

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles spent in WAIT before the request is re-issued.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 PCSrc  input  1: redirect request from the control path (Branch & Zero); sampled only in VALID.
REQ-006 PCTarget  input  32: redirect target address.
REQ-007 stall  input  1: downstream not ready; holds the current instruction.
REQ-008 imem_req  output  1: instruction-memory read request, one-cycle pulse.
REQ-009 imem_addr  output  32: read address, word-aligned.
REQ-010 imem_rvalid  input  1: read data valid.
REQ-011 imem_rdata  input  32: read data.
REQ-012 Instr  output  32: fetched instruction, fed to the control path and datapath.
REQ-013 PC  output  32: address of Instr.
REQ-014 PCPlus4  output  32: PC + 4, modulo 2^32.
REQ-015 instr_valid  output  1: Instr and PC are valid this cycle.
REQ-016 fetch_err  output  1: sticky error flag, set on misaligned target or timeout.

Function
REQ-017 The FSM SHALL have three states: FETCH, WAIT and VALID.
REQ-018 FETCH SHALL assert imem_req=1 with imem_addr=fetch_pc for exactly one cycle, then go to WAIT.
REQ-019 WAIT SHALL ignore imem_rvalid in the same cycle as imem_req, so the minimum memory latency is 1 cycle.
REQ-020 In WAIT, imem_rvalid=1 SHALL capture imem_rdata into Instr and fetch_pc into PC, then go to VALID.
REQ-021 instr_valid SHALL be 1 exactly while in VALID.
REQ-022 Minimum latency SHALL be 3 cycles: FETCH cycle to the first VALID cycle.
REQ-023 VALID with stall=1 SHALL hold Instr, PC and instr_valid unchanged, and SHALL ignore PCSrc.
REQ-024 VALID with stall=0 SHALL set fetch_pc to {PCTarget[31:2],2'b00} if PCSrc=1, else to PC+4, then go to FETCH.
REQ-025 PCTarget[1:0]!=0 with PCSrc=1 in an accepted VALID cycle SHALL set fetch_err; the fetch proceeds at the aligned address.
REQ-026 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-027 If the counter reaches TIMEOUT without imem_rvalid, the block SHALL set fetch_err and return to FETCH with the same fetch_pc.
REQ-028 imem_rvalid outside WAIT SHALL be discarded, with no state change.
REQ-029 PC+4 SHALL wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-030 fetch_err SHALL be cleared only by reset.
REQ-031 PCPlus4 SHALL be combinational from PC.

Reset
REQ-032 While reset=1, imem_req SHALL be 0 and the FSM SHALL be in FETCH with fetch_pc=RESET_PC.
REQ-033 On reset: PC=RESET_PC, imem_addr=RESET_PC, Instr=32'h0000_0013 (NOP), instr_valid=0, fetch_err=0, wait counter=0.
REQ-034 The first imem_req SHALL be issued in the first cycle after reset deasserts.
REQ-035 Reset asserted mid-WAIT SHALL abandon the outstanding request; a late imem_rvalid is discarded per REQ-028.

Structure
REQ-036 The shared package riscv_pkg SHALL hold the NOP constant 32'h0000_0013, the fetch-state encoding and the default RESET_PC.
REQ-037 One sub-module, pc_register, SHALL be used: a 32-bit register with synchronous reset to RESET_PC and a load enable, instantiated for both fetch_pc and PC.

Verification
REQ-038 Reset release, memory latency 1, rdata=32'h00500093 -> imem_req at cycle 1 addr 0; instr_valid at cycle 3 with Instr=32'h00500093, PC=0, PCPlus4=4.
REQ-039 Stall held 4 cycles in VALID -> Instr and PC stable, no imem_req, PCSrc toggling ignored; stall release -> next request at addr 4.
REQ-040 PCSrc=1, PCTarget=32'h0000_0100 in an accepted VALID cycle -> next imem_addr=32'h100, fetch_err=0.
REQ-041 PCSrc=1, PCTarget=32'h0000_0102 -> imem_addr=32'h100, fetch_err=1 and still 1 after 10 more cycles.
REQ-042 No imem_rvalid for TIMEOUT=16 cycles -> fetch_err=1 and imem_req re-issued at the same address; a later rvalid is accepted normally.
REQ-043 PC=32'hFFFF_FFFC accepted with PCSrc=0 -> next imem_addr=0; reset pulse mid-WAIT followed by a stray rvalid -> no instr_valid, refetch at RESET_PC.
